// File: rtl/y_bus_arbiter4_pkg.sv
// y_bus_arbiter4_pkg: shared state encodings and default bus sizing for the result-bus arbiter and its clients.
package y_bus_arbiter4_pkg;
  localparam logic IDLE  = 1'b0;
  localparam logic GRANT = 1'b1;
  localparam int DEF_SIZE     = 32;
  localparam int DEF_MAX_HOLD = 4;
  localparam int DEF_CNT_W    = 3;
endpackage

// File: rtl/y_bus_arbiter4_mux.sv
// yMux4to1: 4:1 word multiplexer driven by a 2-bit select.
module yMux4to1 #(
  parameter int SIZE = 32
) (
  input  logic [SIZE-1:0] a0,
  input  logic [SIZE-1:0] a1,
  input  logic [SIZE-1:0] a2,
  input  logic [SIZE-1:0] a3,
  input  logic [1:0]      c,
  output logic [SIZE-1:0] z
);
  assign z = c[1] ? (c[0] ? a3 : a2) : (c[0] ? a1 : a0);
endmodule

// File: rtl/y_bus_arbiter4.sv
// y_bus_arbiter4: round-robin owner of a shared result bus, bursts of at most MAX_HOLD cycles.
module y_bus_arbiter4
  import y_bus_arbiter4_pkg::*;
#(
  parameter int SIZE     = DEF_SIZE,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      req,
  input  logic [SIZE-1:0] a0,
  input  logic [SIZE-1:0] a1,
  input  logic [SIZE-1:0] a2,
  input  logic [SIZE-1:0] a3,
  output logic [3:0]      gnt,
  output logic [1:0]      sel,
  output logic            valid,
  output logic [SIZE-1:0] z
);
  logic            state;
  logic [1:0]      ptr;
  logic [CNT_W-1:0] cnt;
  logic            rel;
  logic            found;
  logic [1:0]      base;
  logic [1:0]      win;
  logic [SIZE-1:0] mux_z;
  assign valid = (state == GRANT);
  assign rel   = valid && (!req[sel] || cnt == CNT_W'(MAX_HOLD - 1));
  // On release the search starts just past the outgoing owner so it can hand off at the same edge.
  assign base  = rel ? sel + 2'd1 : ptr;
  always_comb begin
    found = 1'b0;
    win   = base;
    for (int i = 3; i >= 0; i--) begin
      if (req[base + 2'(i)]) begin
        found = 1'b1;
        win   = base + 2'(i);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 4'b0000;
      sel   <= 2'd0;
      ptr   <= 2'd0;
      cnt   <= '0;
    end else begin
      if (!valid || rel) begin
        state <= found ? GRANT : IDLE;
        gnt   <= found ? 4'b0001 << win : 4'b0000;
        sel   <= found ? win : sel;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (rel) ptr <= sel + 2'd1;
    end
  end
  yMux4to1 #(.SIZE(SIZE)) u_mux (
    .a0(a0),
    .a1(a1),
    .a2(a2),
    .a3(a3),
    .c (sel),
    .z (mux_z)
  );
  assign z = mux_z & {SIZE{valid}};
endmodule

// File: tb/tb_y_bus_arbiter4.sv
// tb_y_bus_arbiter4: directed vector table plus hand-written corner sequences for the round-robin bus arbiter.
module tb_y_bus_arbiter4;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] a0, a1, a2, a3;
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic        valid;
  logic [31:0] z;
  int passed = 0;
  int total  = 0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] av [4];

  y_bus_arbiter4 #(.SIZE(32), .MAX_HOLD(4), .CNT_W(3)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .a0   (a0),
    .a1   (a1),
    .a2   (a2),
    .a3   (a3),
    .gnt  (gnt),
    .sel  (sel),
    .valid(valid),
    .z    (z)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t v(input logic r, input logic [3:0] q, input logic [3:0] g, input logic [1:0] s, input logic vl);
    vec_t t;
    t.rst = r; t.req = q; t.gnt = g; t.sel = s; t.valid = vl;
    return t;
  endfunction

  task automatic push_n(input int n, input logic r, input logic [3:0] q, input logic [3:0] g, input logic [1:0] s, input logic vl);
    for (int k = 0; k < n; k++) vecs.push_back(v(r, q, g, s, vl));
  endtask

  initial begin
    av[0] = 32'h1111_1111; av[1] = 32'h2222_2222; av[2] = 32'hDEAD_BEEF; av[3] = 32'h4444_4444;
    a0 = av[0]; a1 = av[1]; a2 = av[2]; a3 = av[3];
    rst = 1'b1; req = 4'b0000;
    // reset held two cycles with all requesting, then round-robin with everyone asserting
    push_n(2, 1, 4'b1111, 4'b0000, 2'd0, 0);
    push_n(4, 0, 4'b1111, 4'b0001, 2'd0, 1);
    push_n(4, 0, 4'b1111, 4'b0010, 2'd1, 1);
    push_n(4, 0, 4'b1111, 4'b0100, 2'd2, 1);
    push_n(4, 0, 4'b1111, 4'b1000, 2'd3, 1);
    push_n(1, 0, 4'b1111, 4'b0001, 2'd0, 1);
    // owner 0 drops -> 1; owner 1 drops after 2 cycles with req[3] up -> 3
    push_n(2, 0, 4'b1010, 4'b0010, 2'd1, 1);
    push_n(2, 0, 4'b1000, 4'b1000, 2'd3, 1);
    push_n(1, 0, 4'b0000, 4'b0000, 2'd0, 0);
    // wrap-around: owner 2 releases into ptr=3, req=0011 -> 0, then 0010 -> 1
    push_n(1, 0, 4'b0100, 4'b0100, 2'd2, 1);
    push_n(1, 0, 4'b0011, 4'b0001, 2'd0, 1);
    push_n(1, 0, 4'b0010, 4'b0010, 2'd1, 1);
    push_n(1, 0, 4'b0000, 4'b0000, 2'd0, 0);
    // ptr=2 from IDLE: 1010 picks 3, not 1
    push_n(1, 0, 4'b1010, 4'b1000, 2'd3, 1);
    push_n(1, 0, 4'b0000, 4'b0000, 2'd0, 0);
    // sole requester 2 for six cycles, re-granted without a gap, then drop
    push_n(6, 0, 4'b0100, 4'b0100, 2'd2, 1);
    push_n(1, 0, 4'b0000, 4'b0000, 2'd0, 0);
    // reset during owner 2's third cycle, then 1100 -> 2 first
    push_n(3, 0, 4'b0100, 4'b0100, 2'd2, 1);
    push_n(1, 1, 4'b0100, 4'b0000, 2'd0, 0);
    push_n(2, 0, 4'b1100, 4'b0100, 2'd2, 1);
    // non-owner changes ignored until hold expiry, then 3 wins from ptr=3
    push_n(1, 0, 4'b1111, 4'b0100, 2'd2, 1);
    push_n(1, 0, 4'b1110, 4'b0100, 2'd2, 1);
    push_n(1, 0, 4'b1110, 4'b1000, 2'd3, 1);
    push_n(1, 1, 4'b0000, 4'b0000, 2'd0, 0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      req = vecs[i].req;
      @(posedge clk);
      #1;
      check($sformatf("row%0d gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      check($sformatf("row%0d valid", i), 32'(valid), 32'(vecs[i].valid));
      check($sformatf("row%0d z", i), z, vecs[i].valid ? av[vecs[i].sel] : 32'h0);
      if (vecs[i].valid || vecs[i].rst) check($sformatf("row%0d sel", i), 32'(sel), 32'(vecs[i].sel));
    end

    // owner data changes propagate to z within the same cycle
    rst = 1'b0; req = 4'b0010;
    @(posedge clk); #1;
    check("hs gnt1", 32'(gnt), 32'h2);
    a1 = 32'h1234_5678;
    #1;
    check("hs z_follow", z, 32'h1234_5678);
    a0 = 32'hFFFF_FFFF;
    #1;
    check("hs z_nonowner", z, 32'h1234_5678);
    req = 4'b0000;
    @(posedge clk); #1;
    check("hs idle_valid", 32'(valid), 32'h0);
    check("hs idle_z", z, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
